spi_slave_fifo: RTL and testbench
=================================

SPI_SLAVE_FIFO -- requirements
Module: spi_slave_fifo

Interface
REQ-001 SHALL have parameter SPI_MODE, default 1, which selects CPOL = SPI_MODE[1] and CPHA = SPI_MODE[0]; legal values are 0-3.
REQ-002 SHALL have parameter WORD_W, default 8, giving the SPI word width; legal range is 4-32.
REQ-003 SHALL have parameter DEPTH, default 16, giving the depth of each FIFO; DEPTH is a power of 2 and at least 2.
REQ-004 SHALL have parameter IDLE_WORD, default all-ones, which is shifted out on MISO when the TX FIFO underruns.
REQ-005 Ports, in order:
- i_Clk  in  1  sole clock; frequency at least 4x SCLK.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_TX_Word  in  WORD_W  word to transmit on MISO.
- i_TX_Valid  in  1  TX push request.
- o_TX_Ready  out  1  TX FIFO not full.
- o_RX_Word  out  WORD_W  head of the RX FIFO.
- o_RX_Valid  out  1  RX FIFO not empty.
- i_RX_Ready  in  1  RX pop request.
- o_TX_Count  out  $clog2(DEPTH)+1  TX FIFO occupancy.
- o_RX_Count  out  $clog2(DEPTH)+1  RX FIFO occupancy.
- o_Overflow  out  1  sticky flag: RX word dropped.
- o_Underrun  out  1  sticky flag: IDLE_WORD sent.
- i_Clear  in  1  clears both sticky flags.
- i_SPI_Clk  in  1  SCLK, asynchronous to i_Clk.
- i_SPI_MOSI  in  1  serial data in.
- i_SPI_CS_n  in  1  chip select, active-low.
- o_SPI_MISO  out  1  serial data out.
- o_SPI_MISO_OE  out  1  MISO output enable.

Function
REQ-006 i_SPI_Clk, i_SPI_MOSI and i_SPI_CS_n SHALL each pass through a 2-FF synchronizer; edges are detected by comparing sync stage 2 with a third register.
REQ-007 Sample edge SHALL be rising SCLK for modes 0 and 3 and falling SCLK for modes 1 and 2; the shift edge SHALL be the opposite SCLK edge.
REQ-008 SCLK edges SHALL be ignored while synchronized CS_n is 1.
REQ-009 On each sample edge, synchronized MOSI SHALL shift in MSB-first and bit_cnt SHALL increment.
REQ-010 When bit_cnt reaches WORD_W-1, the completed word SHALL be pushed to the RX FIFO and bit_cnt SHALL wrap to 0.
REQ-011 o_RX_Valid SHALL rise exactly 4 i_Clk cycles after the final sample SCLK edge at the pin.
REQ-012 An RX push into a full FIFO SHALL drop the word and set o_Overflow, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-013 TX load: the head of the TX FIFO SHALL be popped into tx_shift, and MISO SHALL equal tx_shift MSB. Load timing depends on CPHA:
- CPHA=0: load on the synchronized CS_n falling edge and on each word completion.
- CPHA=1: load on a shift edge when bit_cnt==0.
REQ-014 On all other shift edges, tx_shift SHALL shift left by one bit.
REQ-015 A load from an empty TX FIFO SHALL use IDLE_WORD and set o_Underrun.
REQ-016 Synchronized CS_n rising mid-word SHALL discard the partial RX word and clear bit_cnt; the TX word already loaded SHALL remain consumed.
REQ-017 o_SPI_MISO_OE SHALL equal the inverse of synchronized CS_n; o_SPI_MISO SHALL be 0 while OE=0.
REQ-018 A TX push SHALL be accepted iff i_TX_Valid && o_TX_Ready.
REQ-019 An RX pop SHALL occur iff o_RX_Valid && i_RX_Ready.
REQ-020 Simultaneous push and pop SHALL leave the count unchanged.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH.
REQ-022 i_Clear SHALL take priority over a same-cycle flag set.

Reset
REQ-023 i_Rst SHALL asynchronously empty both FIFOs and set:
- o_TX_Ready=1, o_RX_Valid=0, both counts=0.
- o_Overflow=0, o_Underrun=0.
- o_SPI_MISO=0, o_SPI_MISO_OE=0.
- bit_cnt=0, synchronizers to CS_n=1 and SCLK=CPOL.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer; after release, the block SHALL wait for a fresh CS_n falling edge.

Verification
REQ-025 Mode 1, WORD_W=8: push 0x5A, master clocks in 0xAA -> MISO bits 0,1,0,1,1,0,1,0; o_RX_Word=0xAA; o_Underrun=0.
REQ-026 Modes 0, 2 and 3: push 0xE9 and 0xCB back-to-back under one CS -> MISO carries 0xE9 then 0xCB with no gap; RX receives 2 words.
REQ-027 Empty TX FIFO, one word clocked -> MISO=0xFF, o_Underrun=1; i_Clear pulse -> 0.
REQ-028 DEPTH=4, 5 words clocked with i_RX_Ready=0 -> o_RX_Count=4, o_Overflow=1, first 4 words intact.
REQ-029 CS_n raised after 3 bits, then a full 0x3C sent -> RX holds only 0x3C.
REQ-030 i_Rst pulsed mid-word -> all outputs at reset values within the same cycle; the next full transfer completes correctly.

Source files
------------

// File: rtl/spi_slave_fifo.sv
// SPI slave with oversampled SCLK/CS_n/MOSI and TX/RX word FIFOs on the system clock.
// Supports all four SPI modes. Sticky flags report RX overflow and TX underrun.

module spi_slave_fifo_buf #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic                       i_Wr,
    input  logic [WIDTH-1:0]           i_Wr_Data,
    input  logic                       i_Rd,
    output logic [WIDTH-1:0]           o_Rd_Data,
    output logic [$clog2(DEPTH):0]     o_Count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge i_Clk) begin
        if (i_Wr) mem[wr_ptr] <= i_Wr_Data;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_Count <= '0;
        end else begin
            if (i_Wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (i_Rd) rd_ptr <= rd_ptr + PTR_ONE;
            case ({i_Wr, i_Rd})
                2'b10:   o_Count <= o_Count + CNT_ONE;
                2'b01:   o_Count <= o_Count - CNT_ONE;
                default: o_Count <= o_Count;
            endcase
        end
    end

    assign o_Rd_Data = mem[rd_ptr];
endmodule

module spi_slave_fifo #(
    parameter int unsigned       SPI_MODE  = 1,
    parameter int unsigned       WORD_W    = 8,
    parameter int unsigned       DEPTH     = 16,
    parameter logic [WORD_W-1:0] IDLE_WORD = '1
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic [WORD_W-1:0]        i_TX_Word,
    input  logic                     i_TX_Valid,
    output logic                     o_TX_Ready,
    output logic [WORD_W-1:0]        o_RX_Word,
    output logic                     o_RX_Valid,
    input  logic                     i_RX_Ready,
    output logic [$clog2(DEPTH):0]   o_TX_Count,
    output logic [$clog2(DEPTH):0]   o_RX_Count,
    output logic                     o_Overflow,
    output logic                     o_Underrun,
    input  logic                     i_Clear,
    input  logic                     i_SPI_Clk,
    input  logic                     i_SPI_MOSI,
    input  logic                     i_SPI_CS_n,
    output logic                     o_SPI_MISO,
    output logic                     o_SPI_MISO_OE
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned BW = $clog2(WORD_W);
    localparam bit CPOL        = SPI_MODE[1];
    localparam bit CPHA        = SPI_MODE[0];
    localparam bit SAMPLE_RISE = (CPOL == CPHA);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
    localparam logic [BW-1:0] BIT_ONE  = 1;

    typedef enum logic [1:0] {ST_RESET, ST_ARM, ST_IDLE, ST_ACTIVE} state_t;

    state_t state, state_nxt;

    logic [2:0]        sclk_s;
    logic [2:0]        cs_s;
    logic [1:0]        mosi_s;
    logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic              in_word, sample_ev, shift_ev, word_done;
    logic              tx_load, tx_shift_en;
    logic [BW-1:0]     bit_cnt;
    logic [WORD_W-1:0] rx_shift, rx_word_q, tx_shift, tx_head;
    logic              rx_push_q;
    logic              tx_empty, tx_full, rx_full;
    logic              tx_push, tx_pop, rx_push, rx_pop;
    logic              ovf_set, und_set;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sclk_s <= {3{CPOL}};
            cs_s   <= '1;
            mosi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], i_SPI_Clk};
            cs_s   <= {cs_s[1:0], i_SPI_CS_n};
            mosi_s <= {mosi_s[0], i_SPI_MOSI};
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign cs_fall   = ~cs_s[1] & cs_s[2];
    assign cs_rise   = cs_s[1] & ~cs_s[2];

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) state <= ST_RESET;
        else       state <= state_nxt;
    end

    // A CS_n still held low across reset must be seen high before a new transfer counts.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_ARM;
            ST_ARM:    if (cs_s[0]) state_nxt = ST_IDLE;
            ST_IDLE:   if (cs_fall) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (cs_s[1]) state_nxt = ST_IDLE;
            default:   state_nxt = ST_RESET;
        endcase
    end

    // Shift edges at bit_cnt==0 either load (CPHA=1) or trail a completed word (CPHA=0),
    // so the freshly loaded MSB is never shifted away.
    always_comb begin
        in_word     = (state == ST_ACTIVE) && !cs_s[1];
        sample_ev   = in_word && (SAMPLE_RISE ? sclk_rise : sclk_fall);
        shift_ev    = in_word && (SAMPLE_RISE ? sclk_fall : sclk_rise);
        word_done   = sample_ev && (bit_cnt == BIT_LAST);
        tx_shift_en = shift_ev && (bit_cnt != '0);
        if (CPHA) tx_load = shift_ev && (bit_cnt == '0);
        else      tx_load = ((state == ST_IDLE) && cs_fall) || word_done;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            rx_word_q <= '0;
            rx_push_q <= 1'b0;
            tx_shift  <= '0;
        end else begin
            rx_push_q <= word_done;
            if (cs_rise) begin
                bit_cnt <= '0;
            end else if (sample_ev) begin
                rx_shift <= {rx_shift[WORD_W-2:0], mosi_s[1]};
                if (word_done) begin
                    bit_cnt   <= '0;
                    rx_word_q <= {rx_shift[WORD_W-2:0], mosi_s[1]};
                end else begin
                    bit_cnt <= bit_cnt + BIT_ONE;
                end
            end
            if (tx_load)          tx_shift <= tx_empty ? IDLE_WORD : tx_head;
            else if (tx_shift_en) tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
        end
    end

    assign tx_empty = (o_TX_Count == '0);
    assign tx_full  = (o_TX_Count == FULL_CNT);
    assign rx_full  = (o_RX_Count == FULL_CNT);
    assign tx_push  = i_TX_Valid && !tx_full;
    assign tx_pop   = tx_load && !tx_empty;
    assign rx_pop   = o_RX_Valid && i_RX_Ready;
    assign rx_push  = rx_push_q && (!rx_full || rx_pop);
    assign ovf_set  = rx_push_q && rx_full && !rx_pop;
    assign und_set  = tx_load && tx_empty;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Overflow <= 1'b0;
            o_Underrun <= 1'b0;
        end else if (i_Clear) begin
            o_Overflow <= 1'b0;
            o_Underrun <= 1'b0;
        end else begin
            if (ovf_set) o_Overflow <= 1'b1;
            if (und_set) o_Underrun <= 1'b1;
        end
    end

    spi_slave_fifo_buf #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_tx_fifo (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Wr      (tx_push),
        .i_Wr_Data (i_TX_Word),
        .i_Rd      (tx_pop),
        .o_Rd_Data (tx_head),
        .o_Count   (o_TX_Count)
    );

    spi_slave_fifo_buf #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_rx_fifo (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Wr      (rx_push),
        .i_Wr_Data (rx_word_q),
        .i_Rd      (rx_pop),
        .o_Rd_Data (o_RX_Word),
        .o_Count   (o_RX_Count)
    );

    assign o_TX_Ready    = !tx_full;
    assign o_RX_Valid    = (o_RX_Count != '0);
    assign o_SPI_MISO_OE = ~cs_s[1];
    assign o_SPI_MISO    = o_SPI_MISO_OE & tx_shift[WORD_W-1];
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Drives four slaves (modes 0-3, mode 2 with DEPTH=4) one at a time as an SPI master
// and checks MISO words, RX words, counts and flags against a queue-based model.

module tb_spi_slave_fifo;
    localparam int H = 8;

    logic       clk, rst, clear, mosi;
    logic [7:0] tx_word;
    logic       sclk [4];
    logic       cs_n [4];
    logic       tx_valid [4];
    logic       rx_ready [4];
    logic       tx_ready [4];
    logic       rx_valid [4];
    logic       ovf [4];
    logic       und [4];
    logic       miso [4];
    logic       oe [4];
    logic [7:0] rx_word [4];
    logic [4:0] tx_cnt [4];
    logic [4:0] rx_cnt [4];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_samp = 0;
    int sel     = 0;
    logic prev_v = 1'b0;

    logic [7:0] m_tx [$];
    logic [7:0] exp_rx [$];
    bit         m_under, m_ovf;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned D = (g == 2) ? 4 : 16;
        logic [$clog2(D):0] tc, rc;
        spi_slave_fifo #(.SPI_MODE(g), .WORD_W(8), .DEPTH(D), .IDLE_WORD(8'hFF)) u_dut (
            .i_Clk         (clk),
            .i_Rst         (rst),
            .i_TX_Word     (tx_word),
            .i_TX_Valid    (tx_valid[g]),
            .o_TX_Ready    (tx_ready[g]),
            .o_RX_Word     (rx_word[g]),
            .o_RX_Valid    (rx_valid[g]),
            .i_RX_Ready    (rx_ready[g]),
            .o_TX_Count    (tc),
            .o_RX_Count    (rc),
            .o_Overflow    (ovf[g]),
            .o_Underrun    (und[g]),
            .i_Clear       (clear),
            .i_SPI_Clk     (sclk[g]),
            .i_SPI_MOSI    (mosi),
            .i_SPI_CS_n    (cs_n[g]),
            .o_SPI_MISO    (miso[g]),
            .o_SPI_MISO_OE (oe[g])
        );
        assign tx_cnt[g] = 5'(tc);
        assign rx_cnt[g] = 5'(rc);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every RX pop is compared with the head of the scoreboard.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst) begin
            if (rx_valid[sel] && rx_ready[sel]) begin
                if (exp_rx.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_word[sel]);
                end else begin
                    e = exp_rx.pop_front();
                    check("rx_word", rx_word[sel], e);
                end
            end
            if (rx_valid[sel] && !prev_v) check("rx_latency", cyc - last_samp, 4);
            prev_v = rx_valid[sel];
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int depth_of(input int d);
        return (d == 2) ? 4 : 16;
    endfunction

    task automatic next_tx(output logic [7:0] w);
        if (m_tx.size() > 0) w = m_tx.pop_front();
        else begin
            w = 8'hFF;
            m_under = 1'b1;
        end
    endtask

    task automatic model_rx(input int d, input logic [7:0] w);
        if (exp_rx.size() < depth_of(d)) exp_rx.push_back(w);
        else m_ovf = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cs_n[i] = 1'b1;
            sclk[i] = i[1];
            tx_valid[i] = 1'b0;
            rx_ready[i] = 1'b0;
        end
        ticks(2);
        rst = 1'b0;
        m_tx.delete();
        exp_rx.delete();
        m_under = 1'b0;
        m_ovf = 1'b0;
        ticks(4);
    endtask

    task automatic push(input int d, input logic [7:0] w);
        tx_word = w;
        tx_valid[d] = 1'b1;
        ticks(1);
        tx_valid[d] = 1'b0;
        if (m_tx.size() < depth_of(d)) m_tx.push_back(w);
    endtask

    task automatic spi_bit(input int d, input logic mo, output logic mi);
        logic cpol, cpha;
        cpol = d[1];
        cpha = d[0];
        if (!cpha) begin
            mosi = mo;
            ticks(H);
            mi = miso[d];
            sclk[d] = ~cpol;
            last_samp = cyc;
            ticks(H);
            sclk[d] = cpol;
        end else begin
            sclk[d] = ~cpol;
            mosi = mo;
            ticks(H);
            mi = miso[d];
            sclk[d] = cpol;
            last_samp = cyc;
            ticks(H);
        end
    endtask

    task automatic xfer(input int d, input int nw, input int part, input bit fixed_en,
                        input logic [7:0] fixed_w);
        logic cpha, mb;
        logic [7:0] cur, mw, got;
        int nb;
        cpha = d[0];
        cs_n[d] = 1'b0;
        ticks(8);
        if (!cpha) next_tx(cur);
        for (int w = 0; w <= nw; w++) begin
            nb = (w < nw) ? 8 : part;
            if (nb == 0) break;
            mw = fixed_en ? fixed_w : 8'($urandom_range(0, 255));
            if (cpha) next_tx(cur);
            got = '0;
            for (int b = 0; b < nb; b++) begin
                if (b == 7) model_rx(d, mw);
                spi_bit(d, mw[7-b], mb);
                got = {got[6:0], mb};
            end
            if (nb == 8) begin
                check("miso_word", got, cur);
                if (!cpha) next_tx(cur);
            end
        end
        ticks(H);
        cs_n[d] = 1'b1;
        ticks(8);
    endtask

    task automatic check_reset(input int d);
        check("rst_tx_ready", tx_ready[d], 1);
        check("rst_rx_valid", rx_valid[d], 0);
        check("rst_tx_cnt", tx_cnt[d], 0);
        check("rst_rx_cnt", rx_cnt[d], 0);
        check("rst_ovf", ovf[d], 0);
        check("rst_und", und[d], 0);
        check("rst_miso", miso[d], 0);
        check("rst_oe", oe[d], 0);
    endtask

    task automatic finish_section(input int d);
        ticks(20);
        check("rx_drain", exp_rx.size(), 0);
        check("underrun", und[d], m_under);
        check("overflow", ovf[d], m_ovf);
        check("tx_cnt_end", tx_cnt[d], m_tx.size());
    endtask

    initial begin
        logic mb;
        int d, k, nw;
        int modes [3] = '{0, 2, 3};
        rst = 1'b1;
        clear = 1'b0;
        mosi = 1'b0;
        tx_word = '0;
        for (int i = 0; i < 4; i++) begin
            cs_n[i] = 1'b1;
            sclk[i] = i[1];
            tx_valid[i] = 1'b0;
            rx_ready[i] = 1'b0;
        end
        ticks(3);
        for (int i = 0; i < 4; i++) check_reset(i);
        do_reset();

        // Mode 1 directed word.
        sel = 1;
        rx_ready[1] = 1'b1;
        push(1, 8'h5A);
        xfer(1, 1, 0, 1'b1, 8'hAA);
        finish_section(1);

        // Back-to-back words under one CS in modes 0, 2, 3.
        foreach (modes[i]) begin
            d = modes[i];
            do_reset();
            sel = d;
            rx_ready[d] = 1'b1;
            push(d, 8'hE9);
            push(d, 8'hCB);
            check("tx_cnt_push", tx_cnt[d], 2);
            xfer(d, 2, 0, 1'b0, 8'h00);
            finish_section(d);
        end

        // Underrun and clear.
        do_reset();
        sel = 1;
        rx_ready[1] = 1'b1;
        xfer(1, 1, 0, 1'b0, 8'h00);
        finish_section(1);
        clear = 1'b1;
        ticks(1);
        clear = 1'b0;
        ticks(1);
        check("und_cleared", und[1], 0);

        // Overflow on the DEPTH=4 instance.
        do_reset();
        sel = 2;
        xfer(2, 5, 0, 1'b0, 8'h00);
        ticks(10);
        check("rx_cnt_full", rx_cnt[2], exp_rx.size());
        check("ovf_full", ovf[2], m_ovf);
        rx_ready[2] = 1'b1;
        finish_section(2);
        check("rx_cnt_empty", rx_cnt[2], 0);

        // Aborted partial word, then a full word.
        do_reset();
        sel = 1;
        rx_ready[1] = 1'b1;
        push(1, 8'($urandom_range(0, 255)));
        push(1, 8'($urandom_range(0, 255)));
        xfer(1, 0, 3, 1'b0, 8'h00);
        xfer(1, 1, 0, 1'b1, 8'h3C);
        finish_section(1);

        // Randomized transfers over all modes.
        for (int it = 0; it < 10; it++) begin
            d = $urandom_range(0, 3);
            do_reset();
            sel = d;
            rx_ready[d] = 1'b1;
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) push(d, 8'($urandom_range(0, 255)));
            check("tx_cnt_rand", tx_cnt[d], m_tx.size());
            nw = $urandom_range(1, 3);
            xfer(d, nw, 0, 1'b0, 8'h00);
            finish_section(d);
        end

        // Reset mid-word, then a fresh transfer.
        do_reset();
        sel = 3;
        rx_ready[3] = 1'b1;
        push(3, 8'h11);
        cs_n[3] = 1'b0;
        ticks(8);
        for (int b = 0; b < 4; b++) spi_bit(3, 1'($urandom_range(0, 1)), mb);
        #2 rst = 1'b1;
        #1 check_reset(3);
        do_reset();
        rx_ready[3] = 1'b1;
        push(3, 8'h96);
        xfer(3, 1, 0, 1'b0, 8'h00);
        finish_section(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
